// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, FIFO entry layout and sink FSM state type for the
// convolution output path.
//   PXL_W   - quantized output pixel width
//   ACC_W   - convolution accumulator width
//   ENTRY_W - FIFO entry width: {data[PXL_W-1:0], eol, last}
package conv_pkg;

  localparam int unsigned PXL_W   = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned ENTRY_W = PXL_W + 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags.
// Read data is taken directly from the storage registers (no combinational
// path from the write side), so an entry is visible the cycle after it is
// written. A write while full is accepted only when a read happens in the
// same cycle. DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   i_clk, i_rst_n       - clock, synchronous active-low reset
//   i_wr_en, i_wr_data   - write request and data
//   i_rd_en              - read request (ignored while empty)
//   o_rd_data            - head entry, forced to 0 while empty
//   o_full, o_empty      - occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AddrW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd    = i_rd_en && !o_empty;
  assign w_wr    = i_wr_en && (!o_full || w_rd);

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AddrW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AddrW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AddrW + 1)'(1);
        2'b01:   r_count <= r_count - (AddrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_sink.sv
// conv_out_sink: quantizes convolution accumulator samples to 8-bit pixels,
// tags each with end-of-row / end-of-frame flags and buffers them in a FIFO
// for a ready/valid consumer. Upstream has no backpressure: samples arriving
// while the FIFO cannot take them are dropped and flagged in a sticky
// overflow bit, but still advance the row/column position.
// Build option: define CONV_SINK_ROUND_EN to round to nearest instead of
// truncating when shifting the accumulator down.
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   pxl_in, valid        - accumulator sample and its qualifier
//   out_data, out_valid  - quantized pixel stream, out_ready from consumer
//   out_eol, out_last    - last pixel of row / of frame
//   frame_done           - one-cycle pulse once a frame has fully drained
//   overflow             - sticky: a sample was dropped
//   busy                 - a frame is in progress (ACTIVE or DRAIN)
module conv_out_sink
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 12,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] pxl_in,
  input  logic             valid,
  output logic [PXL_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             out_last,
  output logic             frame_done,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SumW = ACC_W + 1;

  conv_state_e        r_state;
  conv_state_e        w_state_next;
  logic [ColW-1:0]    r_col;
  logic [RowW-1:0]    r_row;
  logic               r_overflow;
  logic               r_frame_done;

  logic [SumW-1:0]    w_shifted;
  logic [PXL_W-1:0]   w_quant;
  logic               w_take;
  logic               w_at_eol;
  logic               w_at_last;
  logic               w_rd;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  // Quantization: shift at full accumulator width (plus a carry bit for the
  // rounding sum), then saturate to the pixel range.
`ifdef CONV_SINK_ROUND_EN
  localparam logic [SumW-1:0] RoundAdd = SumW'((1 << SHIFT) >> 1);
  logic [SumW-1:0] w_sum;
  assign w_sum     = {1'b0, pxl_in} + RoundAdd;
  assign w_shifted = w_sum >> SHIFT;
`else
  assign w_shifted = {1'b0, pxl_in} >> SHIFT;
`endif

  assign w_quant = (w_shifted > SumW'(255)) ? 8'hFF : w_shifted[PXL_W-1:0];

  // Samples are taken (written or dropped) in IDLE and ACTIVE; DRAIN ignores them.
  assign w_take    = valid && (r_state != StDrain);
  assign w_at_eol  = (r_col == ColW'(IMG_W - 1));
  assign w_at_last = w_at_eol && (r_row == RowW'(IMG_H - 1));

  assign w_rd   = out_valid && out_ready;
  assign w_drop = (w_take && w_full && !w_rd) || (valid && (r_state == StDrain));

  assign w_wr_entry = {w_quant, w_at_eol, w_at_last};

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_wr_en  (w_take),
    .i_wr_data(w_wr_entry),
    .i_rd_en  (out_ready),
    .o_rd_data(w_rd_entry),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign {out_data, out_eol, out_last} = w_rd_entry;
  assign out_valid  = !w_empty;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state != StIdle);

  // The last sample may itself be dropped, so leaving ACTIVE depends only on
  // position. Once in DRAIN, an empty FIFO means the final entry has either
  // handshaked or was never stored.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (valid) begin
          w_state_next = w_at_last ? StDrain : StActive;
        end
      end
      StActive: begin
        if (valid && w_at_last) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_empty) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_overflow   <= r_overflow || w_drop;
      r_frame_done <= (r_state == StDrain) && w_empty;
      if (w_state_next == StIdle) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_take) begin
        if (w_at_eol) begin
          r_col <= '0;
          r_row <= w_at_last ? '0 : r_row + RowW'(1);
        end else begin
          r_col <= r_col + ColW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_out_sink.sv
// tb_conv_out_sink: directed bench for conv_out_sink with default parameters
// (12x12 frame, SHIFT=4, DEPTH=16). Expected rounding result follows the
// CONV_SINK_ROUND_EN build option.
module tb_conv_out_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pxl_in;
  logic        valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_eol;
  logic        out_last;
  logic        frame_done;
  logic        overflow;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;

  always #5 clk = ~clk;

  conv_out_sink #(
    .IMG_W(12),
    .IMG_H(12),
    .SHIFT(4),
    .DEPTH(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pxl_in    (pxl_in),
    .valid     (valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eol   (out_eol),
    .out_last  (out_last),
    .frame_done(frame_done),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] q_in  [4];
    logic [7:0]  q_exp [4];
    logic [7:0]  exp_d;

    q_in[0] = 16'h0FF0; q_exp[0] = 8'hFF;
    q_in[1] = 16'h0123; q_exp[1] = 8'h12;
`ifdef CONV_SINK_ROUND_EN
    q_in[2] = 16'h0128; q_exp[2] = 8'h13;
`else
    q_in[2] = 16'h0128; q_exp[2] = 8'h12;
`endif
    q_in[3] = 16'hFFFF; q_exp[3] = 8'hFF;

    // Reset state
    reset = 1'b0; valid = 1'b0; pxl_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_eol", 32'(out_eol), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Full frame, consumer always ready; first four samples are quantizer vectors,
    // the rest are k*16 so the expected pixel equals the sample index.
    out_ready = 1'b1;
    fd_cnt = 0;
    for (int k = 0; k <= 144; k++) begin
      if (k > 0) begin
        exp_d = (k - 1 < 4) ? q_exp[k-1] : 8'(k - 1);
        check("frame_valid", 32'(out_valid), 32'd1);
        check("frame_data", 32'(out_data), 32'(exp_d));
        check("frame_eol", 32'(out_eol), 32'(((k - 1) % 12) == 11));
        check("frame_last", 32'(out_last), 32'((k - 1) == 143));
      end
      if (k == 2) check("frame_busy", 32'(busy), 32'd1);
      fd_cnt += int'(frame_done);
      if (k < 144) begin
        valid = 1'b1;
        pxl_in = (k < 4) ? q_in[k] : 16'(k * 16);
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    repeat (10) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    check("frame_done_pulses", 32'(fd_cnt), 32'd1);
    check("frame_end_busy", 32'(busy), 32'd0);
    check("frame_end_overflow", 32'(overflow), 32'd0);
    check("frame_end_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: 20 samples with consumer stalled, 16 retained
    out_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      valid = 1'b1;
      pxl_in = 16'((j + 1) * 16);
      @(negedge clk);
    end
    valid = 1'b0;
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'd1);
      check("stall_eol", 32'(out_eol), 32'd0);
      check("stall_last", 32'(out_last), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(j + 1));
      check("bp_eol", 32'(out_eol), 32'(j == 11));
      @(negedge clk);
    end
    check("bp_drained", 32'(out_valid), 32'd0);
    // Position must be at sample 20 (row 1, col 8): sample 23 ends the row.
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        check("resume_data", 32'(out_data), 32'(20 + k));
        check("resume_eol", 32'(out_eol), 32'(k == 4));
      end
      if (k < 4) begin
        valid = 1'b1;
        pxl_in = 16'((21 + k) * 16);
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end
    check("bp_overflow_sticky", 32'(overflow), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_out_valid", 32'(out_valid), 32'd0);

    // Full FIFO with simultaneous write and read handshake
    out_ready = 1'b0;
    for (int j = 0; j < 16; j++) begin
      valid = 1'b1;
      pxl_in = 16'((j + 1) * 16);
      @(negedge clk);
    end
    check("full_no_overflow", 32'(overflow), 32'd0);
    valid = 1'b1;
    pxl_in = 16'(17 * 16);
    out_ready = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    out_ready = 1'b0;
    check("full_rw_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("full_rw_data", 32'(out_data), 32'(j + 2));
      @(negedge clk);
    end
    check("full_rw_empty", 32'(out_valid), 32'd0);

    // Mid-frame reset after sample 50
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fd_cnt = 0;
    out_ready = 1'b0;
    for (int j = 0; j <= 50; j++) begin
      valid = 1'b1;
      pxl_in = 16'((j + 1) * 16);
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    valid = 1'b0;
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    check("mr_pre_overflow", 32'(overflow), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_out_data", 32'(out_data), 32'd0);
    check("mr_overflow", 32'(overflow), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    fd_cnt += int'(frame_done);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      fd_cnt += int'(frame_done);
    end
    check("mr_no_frame_done", 32'(fd_cnt), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        check("nf_data", 32'(out_data), 32'(k));
        check("nf_eol", 32'(out_eol), 32'(k == 12));
        check("nf_last", 32'(out_last), 32'd0);
      end
      if (k < 12) begin
        valid = 1'b1;
        pxl_in = 16'((k + 1) * 16);
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
